// File: rtl/mbist_sched.sv
// mbist_sched: runs the shared MBIST engine over MEM_NUM memories in turn,
// lowest index first, logging per-memory fail and timeout status.
module mbist_sched #(
  parameter int unsigned MEM_NUM   = 4,
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 abort,
  input  logic [MEM_NUM-1:0]   mem_mask,
  input  logic [TIMEOUT_W-1:0] timeout,
  input  logic                 eng_done,
  input  logic [MEM_NUM-1:0]   fail_flags,
  output logic [MEM_NUM-1:0]   eng_sel,
  output logic                 eng_start,
  output logic                 busy,
  output logic                 done,
  output logic [MEM_NUM-1:0]   fail_map,
  output logic [MEM_NUM-1:0]   timeout_map
);

  localparam int unsigned IDX_W = (MEM_NUM > 1) ? $clog2(MEM_NUM) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_LAUNCH,
    S_RUN,
    S_FINISH
  } state_e;

  state_e               state_q, state_d;
  logic [MEM_NUM-1:0]   pending_q, pending_d;
  logic [TIMEOUT_W-1:0] timer_q, timer_d;
  logic [IDX_W-1:0]     cur_idx_q, cur_idx_d;
  logic [MEM_NUM-1:0]   eng_sel_q, eng_sel_d;
  logic [MEM_NUM-1:0]   fail_map_q, fail_map_d;
  logic [MEM_NUM-1:0]   timeout_map_q, timeout_map_d;
  logic                 eng_start_q, busy_q, done_q;
  logic [IDX_W-1:0]     next_idx;

  // Index of the lowest set bit; higher bits are overwritten by lower ones.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [MEM_NUM-1:0] v);
    lowest_idx = '0;
    for (int i = int'(MEM_NUM) - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = IDX_W'(i);
    end
  endfunction

  assign next_idx = lowest_idx(pending_q);

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and datapath updates; abort overrides everything mid-session.
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    timer_d       = timer_q;
    cur_idx_d     = cur_idx_q;
    eng_sel_d     = eng_sel_q;
    fail_map_d    = fail_map_q;
    timeout_map_d = timeout_map_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pending_d     = mem_mask;
          fail_map_d    = '0;
          timeout_map_d = '0;
          state_d       = S_SCAN;
        end
      end
      S_SCAN: begin
        if (pending_q == '0) begin
          state_d = S_FINISH;
        end else begin
          cur_idx_d           = next_idx;
          pending_d[next_idx] = 1'b0;
          eng_sel_d           = MEM_NUM'(1) << next_idx;
          state_d             = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        timer_d = timeout;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (eng_done) begin
          fail_map_d[cur_idx_q] = fail_flags[cur_idx_q];
          eng_sel_d             = '0;
          state_d               = S_SCAN;
        end else if (timer_q == TIMEOUT_W'(1)) begin
          timeout_map_d[cur_idx_q] = 1'b1;
          fail_map_d[cur_idx_q]    = 1'b1;
          eng_sel_d                = '0;
          state_d                  = S_SCAN;
        end else if (timer_q != '0) begin
          timer_d = timer_q - TIMEOUT_W'(1);
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort && (state_q inside {S_SCAN, S_LAUNCH, S_RUN})) begin
      fail_map_d    = fail_map_q;
      timeout_map_d = timeout_map_q;
      eng_sel_d     = '0;
      pending_d     = '0;
      state_d       = S_FINISH;
    end
  end

  // Datapath and output registers; pulses are decoded from the next state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending_q     <= '0;
      timer_q       <= '0;
      cur_idx_q     <= '0;
      eng_sel_q     <= '0;
      fail_map_q    <= '0;
      timeout_map_q <= '0;
      eng_start_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      timer_q       <= timer_d;
      cur_idx_q     <= cur_idx_d;
      eng_sel_q     <= eng_sel_d;
      fail_map_q    <= fail_map_d;
      timeout_map_q <= timeout_map_d;
      eng_start_q   <= (state_d == S_LAUNCH);
      busy_q        <= (state_d != S_IDLE);
      done_q        <= (state_d == S_FINISH);
    end
  end

  assign eng_sel     = eng_sel_q;
  assign eng_start   = eng_start_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign fail_map    = fail_map_q;
  assign timeout_map = timeout_map_q;

endmodule

// File: tb/tb_mbist_sched.sv
// Directed self-checking bench for mbist_sched (MEM_NUM=4, TIMEOUT_W=16).
module tb_mbist_sched;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic        abort;
  logic [3:0]  mem_mask;
  logic [15:0] timeout;
  logic        eng_done;
  logic [3:0]  fail_flags;
  logic [3:0]  eng_sel;
  logic        eng_start;
  logic        busy;
  logic        done;
  logic [3:0]  fail_map;
  logic [3:0]  timeout_map;

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;
  int base;

  mbist_sched #(.MEM_NUM(4), .TIMEOUT_W(16)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .abort       (abort),
    .mem_mask    (mem_mask),
    .timeout     (timeout),
    .eng_done    (eng_done),
    .fail_flags  (fail_flags),
    .eng_sel     (eng_sel),
    .eng_start   (eng_start),
    .busy        (busy),
    .done        (done),
    .fail_map    (fail_map),
    .timeout_map (timeout_map)
  );

  always #5 clk = ~clk;

  // Count engine launch pulses, sampled mid-cycle.
  always @(negedge clk) if (eng_start === 1'b1) start_cnt++;

  // Hard stop if the directed sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input string fld, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s: observed=%b expected=%b", tag, fld, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] sel, input logic st, input logic bs,
                         input logic dn, input logic [3:0] fm, input logic [3:0] tm);
    chk(tag, "eng_sel",     eng_sel,             sel);
    chk(tag, "eng_start",   {3'b000, eng_start}, {3'b000, st});
    chk(tag, "busy",        {3'b000, busy},      {3'b000, bs});
    chk(tag, "done",        {3'b000, done},      {3'b000, dn});
    chk(tag, "fail_map",    fail_map,            fm);
    chk(tag, "timeout_map", timeout_map,         tm);
  endtask

  task automatic chk_starts(input string tag, input int exp);
    chk(tag, "starts", 4'(start_cnt - base), 4'(exp));
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; abort = 1'b0; mem_mask = 4'b0;
    timeout = 16'd0; eng_done = 1'b0; fail_flags = 4'b0;
    #12;
    chk_all("reset", 4'b0000, 0, 0, 0, 4'b0000, 4'b0000);
    rstn = 1'b1;
    tick();
    chk_all("idle", 4'b0000, 0, 0, 0, 4'b0000, 4'b0000);

    // Single memory pass, done 10 cycles after eng_start.
    base = start_cnt; mem_mask = 4'b0100; timeout = 16'd0; start = 1'b1;
    tick(); start = 1'b0;                                    // cycle 1
    chk_all("t1_c1", 4'b0000, 0, 1, 0, 4'b0000, 4'b0000);
    tick();                                                  // cycle 2
    chk_all("t1_c2", 4'b0100, 1, 1, 0, 4'b0000, 4'b0000);
    tick();                                                  // cycle 3
    chk_all("t1_c3", 4'b0100, 0, 1, 0, 4'b0000, 4'b0000);
    repeat (8) tick();                                       // cycle 11
    chk_all("t1_c11", 4'b0100, 0, 1, 0, 4'b0000, 4'b0000);
    tick(); eng_done = 1'b1;                                 // cycle 12
    tick(); eng_done = 1'b0;                                 // cycle 13
    chk_all("t1_scan", 4'b0000, 0, 1, 0, 4'b0000, 4'b0000);
    tick();
    chk_all("t1_done", 4'b0000, 0, 1, 1, 4'b0000, 4'b0000);
    tick();
    chk_all("t1_idle", 4'b0000, 0, 0, 0, 4'b0000, 4'b0000);
    chk_starts("t1", 1);

    // Multi-memory ordering with a failure on memory 1.
    base = start_cnt; mem_mask = 4'b1011; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    chk_all("t2_m0", 4'b0001, 1, 1, 0, 4'b0000, 4'b0000);
    tick(); eng_done = 1'b1;
    tick(); eng_done = 1'b0;
    chk_all("t2_s0", 4'b0000, 0, 1, 0, 4'b0000, 4'b0000);
    tick();
    chk_all("t2_m1", 4'b0010, 1, 1, 0, 4'b0000, 4'b0000);
    tick(); eng_done = 1'b1; fail_flags = 4'b0010;
    tick(); eng_done = 1'b0; fail_flags = 4'b0000;
    chk_all("t2_s1", 4'b0000, 0, 1, 0, 4'b0010, 4'b0000);
    tick();
    chk_all("t2_m3", 4'b1000, 1, 1, 0, 4'b0010, 4'b0000);
    tick(); eng_done = 1'b1; fail_flags = 4'b0001;           // only bit 3 is sampled
    tick(); eng_done = 1'b0; fail_flags = 4'b0000;
    chk_all("t2_s3", 4'b0000, 0, 1, 0, 4'b0010, 4'b0000);
    tick();
    chk_all("t2_done", 4'b0000, 0, 1, 1, 4'b0010, 4'b0000);
    tick();
    chk_starts("t2", 3);

    // Timeout of 5 with no eng_done.
    base = start_cnt; mem_mask = 4'b0001; timeout = 16'd5; start = 1'b1;
    tick(); start = 1'b0;
    chk_all("t3_c1", 4'b0000, 0, 1, 0, 4'b0000, 4'b0000);
    tick(); tick();                                          // RUN 1
    repeat (4) tick();                                       // RUN 5
    chk_all("t3_run5", 4'b0001, 0, 1, 0, 4'b0000, 4'b0000);
    tick();
    chk_all("t3_scan", 4'b0000, 0, 1, 0, 4'b0001, 4'b0001);
    tick();
    chk_all("t3_done", 4'b0000, 0, 1, 1, 4'b0001, 4'b0001);
    tick();
    chk_all("t3_hold", 4'b0000, 0, 0, 0, 4'b0001, 4'b0001);

    // eng_done collides with expiry on RUN 5: done wins.
    start = 1'b1; fail_flags = 4'b0000;
    tick(); start = 1'b0;
    chk_all("t4_clr", 4'b0000, 0, 1, 0, 4'b0000, 4'b0000);
    tick(); tick();
    repeat (4) tick();
    eng_done = 1'b1;
    tick(); eng_done = 1'b0;
    chk_all("t4_scan", 4'b0000, 0, 1, 0, 4'b0000, 4'b0000);
    tick(); tick();

    // Abort mid-RUN; a start while busy is ignored.
    base = start_cnt; mem_mask = 4'b0011; timeout = 16'd0; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    start = 1'b1; mem_mask = 4'b1111;
    tick(); start = 1'b0;
    chk_all("t5_run", 4'b0001, 0, 1, 0, 4'b0000, 4'b0000);
    abort = 1'b1;
    tick(); abort = 1'b0;
    chk_all("t5_abort", 4'b0000, 0, 1, 1, 4'b0000, 4'b0000);
    tick();
    chk_all("t5_idle", 4'b0000, 0, 0, 0, 4'b0000, 4'b0000);
    tick(); tick();
    chk_starts("t5", 1);

    // Empty mask.
    base = start_cnt; mem_mask = 4'b0000; start = 1'b1;
    tick(); start = 1'b0;
    chk_all("t6_c1", 4'b0000, 0, 1, 0, 4'b0000, 4'b0000);
    tick();
    chk_all("t6_c2", 4'b0000, 0, 1, 1, 4'b0000, 4'b0000);
    tick();
    chk_all("t6_c3", 4'b0000, 0, 0, 0, 4'b0000, 4'b0000);
    chk_starts("t6", 0);

    // Asynchronous reset during RUN after a failing memory 0 result.
    mem_mask = 4'b0011; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); eng_done = 1'b1; fail_flags = 4'b0001;
    tick(); eng_done = 1'b0; fail_flags = 4'b0000;
    tick(); tick();                                          // RUN for memory 1
    chk_all("t7_run", 4'b0010, 0, 1, 0, 4'b0001, 4'b0000);
    #2 rstn = 1'b0;
    #1;
    chk_all("t7_rst", 4'b0000, 0, 0, 0, 4'b0000, 4'b0000);
    @(negedge clk); rstn = 1'b1;
    tick();
    chk_all("t7_idle", 4'b0000, 0, 0, 0, 4'b0000, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
